gmsk_symbol_feeder: RTL and testbench
=====================================

GMSK_SYMBOL_FEEDER -- requirements
Module: gmsk_symbol_feeder

Interface
REQ-001 SHALL have parameter CLOCKS_PER_SAMPLE, default 8: clocks between sample_strobe pulses.
REQ-002 SHALL have parameter SAMPLES_PER_SYMBOL, default 128: sample_strobe pulses per symbol.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: input byte FIFO entries, power of two.
REQ-004 SHALL have port clock, input, 1: sole clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: low freezes the timing counters; no strobes are issued.
REQ-007 SHALL have port byte_in, input, 8: data byte to transmit.
REQ-008 SHALL have port byte_valid, input, 1: byte_in is valid.
REQ-009 SHALL have port byte_ready, output, 1: FIFO can accept a byte.
REQ-010 SHALL have port sample_strobe, output, 1: one-clock pulse per modulator sample.
REQ-011 SHALL have port symbol_strobe, output, 1: one-clock pulse at each symbol boundary.
REQ-012 SHALL have port symbol_window, output, 3: differentially encoded symbols {d[n-1], d[n], d[n+1]} that select the modulator curve.
REQ-013 SHALL have port underrun, output, 1: one-clock pulse when a fill bit is inserted.

Function
REQ-014 SHALL keep clk_cnt in 0..CLOCKS_PER_SAMPLE-1, incrementing each clock while enable=1 and wrapping to 0.
REQ-015 SHALL register sample_strobe=1 for the single clock after clk_cnt==CLOCKS_PER_SAMPLE-1 with enable=1.
REQ-016 SHALL keep samp_cnt in 0..SAMPLES_PER_SYMBOL-1, incrementing on each sample_strobe event and wrapping to 0.
REQ-017 SHALL assert symbol_strobe in the same cycle as the sample_strobe that wraps samp_cnt, so the downstream counter restarts at sample 0.
REQ-018 SHALL leave clk_cnt and samp_cnt unchanged while enable=0, and resume from the held values.
REQ-019 SHALL complete a byte handshake in a cycle where byte_valid=1 and byte_ready=1; byte_ready SHALL equal not-full, registered, with no bypass.
REQ-020 SHALL serialize each byte LSB first, with one bit consumed per symbol_strobe.
REQ-021 SHALL pop the FIFO in the cycle its bit 7 is consumed; a push and a pop in the same cycle SHALL both take effect.
REQ-022 SHALL compute d = b XOR b_prev for each consumed bit, then b_prev <= b.
REQ-023 SHALL update on symbol_strobe as symbol_window <= {symbol_window[1:0], d}, visible the cycle after the strobe.
REQ-024 SHALL, when the FIFO is empty at a symbol_strobe, consume fill bit b=0, pulse underrun for that cycle, and leave bit index at 0.
REQ-025 SHALL place the first bit of a byte pushed into an empty FIFO in symbol_window[0] after the next symbol_strobe that occurs at least 1 clock after the push.

Reset
REQ-026 SHALL clear clk_cnt, samp_cnt, bit index, b_prev and FIFO pointers while reset=1, at any time, discarding queued bytes.
REQ-027 SHALL drive sample_strobe=0, symbol_strobe=0, underrun=0, symbol_window=3'b000 and byte_ready=1 during reset and on the first clock after release.

Structure
REQ-028 SHALL take BITS_PER_SAMPLE, SAMPLES_PER_SYMBOL and CLOCKS_PER_SAMPLE defaults from shared package gmsk_pkg, which the modulator also uses.
REQ-029 SHALL implement the byte FIFO as sub-module gmsk_byte_fifo, with push/pop/full/empty and asynchronous reset.
REQ-030 SHALL keep the timing generator and serializer in gmsk_symbol_feeder.

Verification
REQ-031 SHALL cover strobe timing: enable=1 for 2048 clocks -> sample_strobe every 8 clocks (256 pulses), symbol_strobe every 1024 clocks, coincident with a sample_strobe.
REQ-032 SHALL cover encoding: push 0xA5 after reset -> consumed bits 1,0,1,0,0,1,0,1; d sequence 1,1,1,1,0,1,1,1; symbol_window tracks the last three values.
REQ-033 SHALL cover backpressure: push 5 bytes back-to-back with FIFO_DEPTH=4 -> byte_ready=0 after the 4th; 5th byte accepted in the cycle following the first pop; all 40 bits are emitted in order.
REQ-034 SHALL cover underrun: no data for 3 symbols -> 3 underrun pulses, fill bits 0, symbol_window 3'b000 from b_prev=0.
REQ-035 SHALL cover enable gating: drop enable at clk_cnt=5 for 20 clocks -> no strobes; next sample_strobe arrives 3 enabled clocks after resume.
REQ-036 SHALL cover reset mid-operation: assert reset mid-byte with 2 bytes queued -> outputs cleared asynchronously, byte_ready=1, and no stale bits after release.

Source files
------------

// File: rtl/gmsk_pkg.sv
// Shared GMSK constants and helpers, used by the symbol feeder and the modulator.
package gmsk_pkg;

  localparam int BITS_PER_SAMPLE    = 12;
  localparam int SAMPLES_PER_SYMBOL = 128;
  localparam int CLOCKS_PER_SAMPLE  = 8;
  localparam int FIFO_DEPTH         = 4;

  typedef logic [7:0] byte_t;
  typedef logic [2:0] symbol_window_t;

  // Differential encoding: a symbol is 1 whenever the data bit changes.
  function automatic logic diff_encode(input logic b, input logic b_prev);
    return b ^ b_prev;
  endfunction

endpackage

// File: rtl/gmsk_symbol_feeder_if.sv
// Byte stream handshake into the symbol feeder.
interface gmsk_symbol_feeder_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/gmsk_byte_fifo.sv
// Small byte FIFO with registered full flag; depth must be a power of two.
module gmsk_byte_fifo
  import gmsk_pkg::*;
#(
  parameter int DEPTH = gmsk_pkg::FIFO_DEPTH
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output byte_t pop_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  byte_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + (AW+1)'(1);
          full  <= (count == (AW+1)'(DEPTH - 1));
        end
        2'b01: begin
          count <= count - (AW+1)'(1);
          full  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gmsk_symbol_feeder.sv
// Sample/symbol timing generator and LSB-first, differentially encoded bit
// serializer feeding a 3-symbol window to the GMSK modulator.
module gmsk_symbol_feeder
  import gmsk_pkg::*;
#(
  parameter int CLOCKS_PER_SAMPLE  = gmsk_pkg::CLOCKS_PER_SAMPLE,
  parameter int SAMPLES_PER_SYMBOL = gmsk_pkg::SAMPLES_PER_SYMBOL,
  parameter int FIFO_DEPTH         = gmsk_pkg::FIFO_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  gmsk_symbol_feeder_if.slave        byte_port,
  output logic                       sample_strobe,
  output logic                       symbol_strobe,
  output symbol_window_t             symbol_window,
  output logic                       underrun
);

  localparam int CW = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;
  localparam int SW = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;

  logic [CW-1:0] clk_cnt;
  logic [SW-1:0] samp_cnt;
  logic          tick;
  logic          samp_wrap;

  logic [2:0]    bit_idx;
  logic          b_prev;
  logic          cur_bit;
  byte_t         fifo_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

  assign tick      = enable && (clk_cnt == CW'(CLOCKS_PER_SAMPLE - 1));
  assign samp_wrap = (samp_cnt == SW'(SAMPLES_PER_SYMBOL - 1));

  // Both strobes are registered from the same tick, so a symbol boundary
  // always lands on the sample that restarts the modulator's sample count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_cnt       <= '0;
      samp_cnt      <= '0;
      sample_strobe <= 1'b0;
      symbol_strobe <= 1'b0;
    end else begin
      sample_strobe <= tick;
      symbol_strobe <= tick && samp_wrap;
      if (enable) clk_cnt <= tick ? '0 : clk_cnt + CW'(1);
      if (tick)   samp_cnt <= samp_wrap ? '0 : samp_cnt + SW'(1);
    end
  end

  assign byte_port.byte_ready = ~fifo_full;
  assign fifo_push = byte_port.byte_valid && byte_port.byte_ready;
  assign fifo_pop  = symbol_strobe && !fifo_empty && (bit_idx == 3'd7);
  assign cur_bit   = fifo_data[bit_idx];

  gmsk_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (byte_port.byte_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // An empty FIFO at a symbol boundary sends a 0 fill bit so the modulator
  // never stalls; underrun flags it alongside the window update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_idx       <= '0;
      b_prev        <= 1'b0;
      symbol_window <= '0;
      underrun      <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (symbol_strobe) begin
        if (fifo_empty) begin
          symbol_window <= {symbol_window[1:0], diff_encode(1'b0, b_prev)};
          b_prev        <= 1'b0;
          bit_idx       <= '0;
          underrun      <= 1'b1;
        end else begin
          symbol_window <= {symbol_window[1:0], diff_encode(cur_bit, b_prev)};
          b_prev        <= cur_bit;
          bit_idx       <= bit_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gmsk_symbol_feeder.sv
// Directed-vector bench for gmsk_symbol_feeder with default parameters.
module tb_gmsk_symbol_feeder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sample_strobe;
  logic       symbol_strobe;
  logic       underrun;
  logic [2:0] symbol_window;

  int         checks = 0;
  int         errors = 0;

  logic       exp_prev;
  logic [2:0] exp_window;

  gmsk_symbol_feeder_if byte_if ();

  gmsk_symbol_feeder dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .byte_port     (byte_if),
    .sample_strobe (sample_strobe),
    .symbol_strobe (symbol_strobe),
    .symbol_window (symbol_window),
    .underrun      (underrun)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    byte_if.byte_valid = 1'b0;
    byte_if.byte_in = 8'h00;
    step();
    step();
    reset = 1'b0;
    exp_prev = 1'b0;
    exp_window = 3'b000;
  endtask

  // Reference encoder: d = b ^ previous bit, shifted into the window.
  task automatic model_bit(input logic b);
    logic d;
    d = b ^ exp_prev;
    exp_prev = b;
    exp_window = {exp_window[1:0], d};
  endtask

  // Returns just after the edge that consumes a bit at the next symbol boundary.
  task automatic wait_symbol(output logic ok, output logic ready_at_strobe);
    ok = 1'b0;
    ready_at_strobe = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (symbol_strobe) begin
        ok = 1'b1;
        break;
      end
    end
    ready_at_strobe = byte_if.byte_ready;
    step();
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    #3;
    obs = {sample_strobe, symbol_strobe, underrun, symbol_window, byte_if.byte_ready};
    checks++;
    if (obs !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, required %b", obs, 7'b0000001);
    end
    step();
    reset = 1'b0;
    enable = 1'b1;
    step();
    obs = {sample_strobe, symbol_strobe, underrun, symbol_window, byte_if.byte_ready};
    checks++;
    if (obs !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL first_clock_after_release: got %b, required %b", obs, 7'b0000001);
    end
  endtask

  task automatic test_strobe_timing();
    int cnt_s = 0, cnt_y = 0, first_s = 0, last_s = 0, bad_gap = 0, bad_coinc = 0;
    int sym_at [2] = '{0, 0};
    do_reset();
    enable = 1'b1;
    for (int i = 1; i <= 2048; i++) begin
      step();
      if (sample_strobe) begin
        if (first_s == 0) first_s = i;
        else if (i - last_s != 8) bad_gap++;
        last_s = i;
        cnt_s++;
      end
      if (symbol_strobe) begin
        if (!sample_strobe) bad_coinc++;
        if (cnt_y < 2) sym_at[cnt_y] = i;
        cnt_y++;
      end
    end
    checks++;
    if (cnt_s !== 256) begin errors++; $display("[TB] FAIL sample_count: got %0d, required 256", cnt_s); end
    checks++;
    if (first_s !== 8) begin errors++; $display("[TB] FAIL first_sample: got clock %0d, required 8", first_s); end
    checks++;
    if (bad_gap !== 0) begin errors++; $display("[TB] FAIL sample_spacing: got %0d bad gaps, required 0", bad_gap); end
    checks++;
    if (cnt_y !== 2) begin errors++; $display("[TB] FAIL symbol_count: got %0d, required 2", cnt_y); end
    checks++;
    if (sym_at[0] !== 1024 || sym_at[1] !== 2048) begin
      errors++;
      $display("[TB] FAIL symbol_position: got %0d,%0d, required 1024,2048", sym_at[0], sym_at[1]);
    end
    checks++;
    if (bad_coinc !== 0) begin errors++; $display("[TB] FAIL symbol_coincident: got %0d lone symbol strobes, required 0", bad_coinc); end
  endtask

  task automatic test_encoding();
    logic [2:0] win_tab [8] = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b101, 3'b011, 3'b111};
    logic ok, rdy;
    do_reset();
    enable = 1'b1;
    byte_if.byte_in = 8'hA5;
    byte_if.byte_valid = 1'b1;
    step();
    byte_if.byte_valid = 1'b0;
    for (int s = 0; s < 8; s++) begin
      wait_symbol(ok, rdy);
      model_bit(s[0] ? (s == 5 || s == 7) : (s == 0 || s == 2));
      checks++;
      if (!ok || symbol_window !== win_tab[s] || underrun !== 1'b0) begin
        errors++;
        $display("[TB] FAIL encode_bit%0d: got ok=%b window=%b underrun=%b, required window=%b underrun=0",
                 s, ok, symbol_window, underrun, win_tab[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5] = '{8'h3C, 8'h01, 8'hFF, 8'h96, 8'h5A};
    logic ok, rdy;
    int bad_ready = 0;
    for (int k = 0; k < 4; k++) begin
      byte_if.byte_in = bytes[k];
      byte_if.byte_valid = 1'b1;
      if (byte_if.byte_ready !== 1'b1) bad_ready++;
      step();
    end
    checks++;
    if (bad_ready !== 0) begin errors++; $display("[TB] FAIL fill_ready: got %0d stalls, required 0", bad_ready); end
    byte_if.byte_in = bytes[4];
    checks++;
    if (byte_if.byte_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_after_4: got byte_ready=%b, required 0", byte_if.byte_ready);
    end
    for (int s = 0; s < 40; s++) begin
      logic [7:0] cur;
      cur = bytes[s / 8];
      wait_symbol(ok, rdy);
      model_bit(cur[s % 8]);
      checks++;
      if (!ok || symbol_window !== exp_window || underrun !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stream_bit%0d: got ok=%b window=%b underrun=%b, required window=%b underrun=0",
                 s, ok, symbol_window, underrun, exp_window);
      end
      if (s == 7) begin
        checks++;
        if (rdy !== 1'b0 || byte_if.byte_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL ready_after_pop: got ready %b before pop, %b after, required 0 then 1",
                   rdy, byte_if.byte_ready);
        end
        step();
        byte_if.byte_valid = 1'b0;
        checks++;
        if (byte_if.byte_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL fifth_accepted: got byte_ready=%b, required 0", byte_if.byte_ready);
        end
      end
    end
  endtask

  task automatic test_underrun();
    logic ok, rdy;
    for (int s = 0; s < 3; s++) begin
      wait_symbol(ok, rdy);
      model_bit(1'b0);
      checks++;
      if (!ok || underrun !== 1'b1 || symbol_window !== exp_window) begin
        errors++;
        $display("[TB] FAIL underrun%0d: got ok=%b underrun=%b window=%b, required underrun=1 window=%b",
                 s, ok, underrun, symbol_window, exp_window);
      end
      step();
      checks++;
      if (underrun !== 1'b0) begin
        errors++;
        $display("[TB] FAIL underrun_pulse%0d: got underrun=%b one clock later, required 0", s, underrun);
      end
    end
    checks++;
    if (symbol_window !== 3'b000) begin
      errors++;
      $display("[TB] FAIL underrun_window: got %b, required 000", symbol_window);
    end
  endtask

  task automatic test_enable_gating();
    logic found = 1'b0;
    int strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sample_strobe) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL gate_sync: got no sample_strobe in 20 clocks, required one"); end
    for (int i = 0; i < 5; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sample_strobe || symbol_strobe) strobes++;
    end
    checks++;
    if (strobes !== 0) begin errors++; $display("[TB] FAIL gated_strobes: got %0d, required 0", strobes); end
    enable = 1'b1;
    step();
    step();
    checks++;
    if (sample_strobe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resume_early: got sample_strobe=%b after 2 clocks, required 0", sample_strobe);
    end
    step();
    checks++;
    if (sample_strobe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resume_third: got sample_strobe=%b after 3 clocks, required 1", sample_strobe);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [2:0] win_tab [3] = '{3'b001, 3'b010, 3'b100};
    logic [6:0] obs;
    logic ok, rdy;
    do_reset();
    enable = 1'b1;
    byte_if.byte_in = 8'hFF;
    byte_if.byte_valid = 1'b1;
    step();
    step();
    byte_if.byte_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      wait_symbol(ok, rdy);
      checks++;
      if (!ok || symbol_window !== win_tab[s]) begin
        errors++;
        $display("[TB] FAIL pre_reset_bit%0d: got ok=%b window=%b, required %b", s, ok, symbol_window, win_tab[s]);
      end
    end
    for (int i = 0; i < 100; i++) step();
    #2 reset = 1'b1;
    #1;
    obs = {sample_strobe, symbol_strobe, underrun, symbol_window, byte_if.byte_ready};
    checks++;
    if (obs !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL async_clear: got %b, required %b", obs, 7'b0000001);
    end
    step();
    step();
    reset = 1'b0;
    exp_prev = 1'b0;
    exp_window = 3'b000;
    step();
    obs = {sample_strobe, symbol_strobe, underrun, symbol_window, byte_if.byte_ready};
    checks++;
    if (obs !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL release_clear: got %b, required %b", obs, 7'b0000001);
    end
    for (int s = 0; s < 2; s++) begin
      wait_symbol(ok, rdy);
      checks++;
      if (!ok || underrun !== 1'b1 || symbol_window !== 3'b000) begin
        errors++;
        $display("[TB] FAIL no_stale%0d: got ok=%b underrun=%b window=%b, required underrun=1 window=000",
                 s, ok, underrun, symbol_window);
      end
    end
  endtask

  initial begin
    byte_if.byte_in = 8'h00;
    byte_if.byte_valid = 1'b0;
    exp_prev = 1'b0;
    exp_window = 3'b000;
    test_reset();
    test_strobe_timing();
    test_encoding();
    test_back_to_back();
    test_underrun();
    test_enable_gating();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
